// File: rtl/gray_counter_conv.sv
// Up/down binary counter that publishes its value in binary and in Gray code, loadable from Gray.
// Latency: one cycle from en/load sampled to bin_q/gray_q/wrap change; tc is combinational.
// Backpressure: none; the counter steps on every enabled cycle, load has priority over en.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset (forces INIT, clears wrap)
//   en         - count enable, one step per cycle while high
//   up_dn      - direction, 1 = increment, 0 = decrement
//   load       - synchronous load strobe, overrides en and up_dn
//   load_gray  - Gray-coded value captured when load is high
//   bin_q      - registered binary count
//   gray_q     - registered Gray code of bin_q, updated on the same edge
//   tc         - terminal count for the current direction (combinational)
//   wrap       - registered one-cycle pulse after a wrap-around step
//
// Optional build: define GRAY_SAT_EN to make the counter saturate at the
// terminal count instead of wrapping (wrap then never asserts).

module gray_counter_conv #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] INIT_BIN  = INIT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);

  // Binary -> Gray: each Gray bit is the XOR of adjacent binary bits; the MSB
  // passes straight through because a zero is shifted in above it.
  function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray -> binary: bin[i] is the XOR of all Gray bits from the MSB down to i.
  // Written as a reduction per bit so there is no self-referencing chain
  // inside one combinational variable.
  function automatic logic [WIDTH-1:0] decode(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    for (int i = 0; i < WIDTH; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_d;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] step_bin;

  assign load_bin = decode(load_gray);

  // Terminal count follows up_dn directly so a direction change is visible
  // in the same cycle and takes effect on the very next enabled edge.
  assign tc = up_dn ? (&bin_q) : ~(|bin_q);

  assign step_bin = up_dn ? (bin_q + ONE) : (bin_q - ONE);

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
`ifdef GRAY_SAT_EN
      // Saturate: a step that would wrap is dropped entirely.
      if (!tc) begin
        bin_d = step_bin;
      end
`else
      bin_d  = step_bin;
      wrap_d = tc;
`endif
    end
  end

  // Gray is always derived from the next binary value so both outputs change
  // on the same edge. For a load this reproduces load_gray exactly, since
  // encode(decode(g)) == g.
  assign gray_d = encode(bin_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= INIT_BIN;
      gray_q <= INIT_GRAY;
      wrap   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap   <= wrap_d;
    end
  end

endmodule
